// File: rtl/demux14_deser.sv
// ---------------------------------------------------------------------------
// demux14_deser: 1:N serial-to-parallel deserializer for the mux select sweep
// stream. Accepted bits are written lane by lane (LSB first) into a staging
// register. The finished word is published on out_c with a one-cycle out_valid.
//
// Optional feature: define DEMUX_PARITY_EN to append one even-parity bit to
// every frame. With it, out_perr flags a parity mismatch for each word.
// Without it, the PAR state is not built and out_perr is tied to 0.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_z       in   1        serial data bit
//   in_valid   in   1        in_z/in_start sampled on this edge
//   in_start   in   1        frame sync, marks the lane-0 bit
//   out_c      out  N_LANES  last completed word, held until the next one
//   out_valid  out  1        one-cycle pulse when out_c updates
//   out_s      out  SEL_W    lane index for the next accepted bit
//   out_busy   out  1        frame in progress
//   out_perr   out  1        parity error, updated with out_valid
// ---------------------------------------------------------------------------
module demux14_deser #(
   parameter int unsigned N_LANES = 4,
   parameter int unsigned SEL_W   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_z,
   input  logic               in_valid,
   input  logic               in_start,
   output logic [N_LANES-1:0] out_c,
   output logic               out_valid,
   output logic [SEL_W-1:0]   out_s,
   output logic               out_busy,
   output logic               out_perr
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
`ifdef DEMUX_PARITY_EN
      ST_COLLECT = 2'd1,
      ST_PAR     = 2'd2
`else
      ST_COLLECT = 2'd1
`endif
   } state_e;

   localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_LANES - 1);

   state_e             state_q, state_d;
   logic [N_LANES-1:0] stage_q, stage_d;
   logic [N_LANES-1:0] out_c_q, out_c_d;
   logic               out_valid_q, out_valid_d;
   logic [SEL_W-1:0]   out_s_q, out_s_d;
   logic               out_busy_q, out_busy_d;
`ifdef DEMUX_PARITY_EN
   logic               out_perr_q, out_perr_d;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      out_c_d     = out_c_q;
      out_valid_d = 1'b0;
      out_s_d     = out_s_q;
`ifdef DEMUX_PARITY_EN
      out_perr_d  = out_perr_q;
`endif
      if (in_valid) begin
         if (in_start) begin
            // Start in any state begins a new frame; a partial one is dropped
            stage_d[0] = in_z;
            out_s_d    = SEL_W'(1);
            state_d    = ST_COLLECT;
         end else begin
            case (state_q)
               ST_COLLECT: begin
                  stage_d[out_s_q] = in_z;
                  out_s_d          = out_s_q + SEL_W'(1);
                  if (out_s_q == LAST_LANE) begin
`ifdef DEMUX_PARITY_EN
                     state_d = ST_PAR;
`else
                     state_d     = ST_IDLE;
                     out_c_d     = stage_d;
                     out_valid_d = 1'b1;
`endif
                  end
               end
`ifdef DEMUX_PARITY_EN
               ST_PAR: begin
                  // Even parity: data bits plus parity bit must xor to 0
                  out_c_d     = stage_q;
                  out_valid_d = 1'b1;
                  out_perr_d  = (^stage_q) ^ in_z;
                  state_d     = ST_IDLE;
               end
`endif
               default: begin
                  // Non-start bit in IDLE is dropped
               end
            endcase
         end
      end
      out_busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         stage_q     <= '0;
         out_c_q     <= '0;
         out_valid_q <= 1'b0;
         out_s_q     <= '0;
         out_busy_q  <= 1'b0;
`ifdef DEMUX_PARITY_EN
         out_perr_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         out_c_q     <= out_c_d;
         out_valid_q <= out_valid_d;
         out_s_q     <= out_s_d;
         out_busy_q  <= out_busy_d;
`ifdef DEMUX_PARITY_EN
         out_perr_q  <= out_perr_d;
`endif
      end
   end

   assign out_c     = out_c_q;
   assign out_valid = out_valid_q;
   assign out_s     = out_s_q;
   assign out_busy  = out_busy_q;
`ifdef DEMUX_PARITY_EN
   assign out_perr  = out_perr_q;
`else
   assign out_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_demux14_deser.sv
// ---------------------------------------------------------------------------
// tb_demux14_deser: directed frames plus randomized traffic for demux14_deser,
// compared every cycle against a bit-count based frame model.
// ---------------------------------------------------------------------------
module tb_demux14_deser;

   localparam int N = 4;
`ifdef DEMUX_PARITY_EN
   localparam int FL = N + 1;
`else
   localparam int FL = N;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_z;
   logic         in_valid;
   logic         in_start;
   logic [N-1:0] out_c;
   logic         out_valid;
   logic [1:0]   out_s;
   logic         out_busy;
   logic         out_perr;

   demux14_deser #(.N_LANES(N), .SEL_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_z      (in_z),
      .in_valid  (in_valid),
      .in_start  (in_start),
      .out_c     (out_c),
      .out_valid (out_valid),
      .out_s     (out_s),
      .out_busy  (out_busy),
      .out_perr  (out_perr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: number of frame bits received so far plus their values
   int           cnt;
   logic         bits [0:N];
   logic [N-1:0] exp_c;
   logic         exp_valid;
   logic         exp_perr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      cnt       = 0;
      exp_c     = '0;
      exp_valid = 1'b0;
      exp_perr  = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic st, input logic z);
      logic x;
      exp_valid = 1'b0;
      if (v) begin
         if (st) begin
            bits[0] = z;
            cnt     = 1;
         end else if (cnt > 0) begin
            bits[cnt] = z;
            cnt++;
            if (cnt == FL) begin
               for (int i = 0; i < N; i++) exp_c[i] = bits[i];
               exp_valid = 1'b1;
`ifdef DEMUX_PARITY_EN
               x = 1'b0;
               for (int i = 0; i <= N; i++) x = x ^ bits[i];
               exp_perr = x;
`endif
               cnt = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      check_eq("out_c",     32'(out_c),     32'(exp_c));
      check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
      check_eq("out_s",     32'(out_s),     32'(cnt % N));
      check_eq("out_busy",  32'(out_busy),  32'(cnt > 0));
      check_eq("out_perr",  32'(out_perr),  32'(exp_perr));
   endtask

   // One clock: drive inputs, step the model at the edge, check just after it
   task automatic cyc(input logic v, input logic st, input logic z);
      in_valid = v;
      in_start = st;
      in_z     = z;
      @(posedge clk);
      model_step(v, st, z);
      #1;
      compare_all();
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic send_frame(input logic [N-1:0] d, input logic par, input int gap);
      for (int i = 0; i < N; i++) begin
         cyc(1'b1, (i == 0), d[i]);
         if (i < N - 1) repeat (gap) idle_cyc();
      end
`ifdef DEMUX_PARITY_EN
      repeat (gap) idle_cyc();
      cyc(1'b1, 1'b0, par);
`else
      if (par !== ^d) $display("note: parity argument ignored in this build");
`endif
   endtask

   task automatic async_reset();
      in_valid = 1'b0;
      in_start = 1'b0;
      rst_n    = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_start = 1'b0;
      in_z     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check_eq("rst_c", 32'(out_c), 32'h0);
      check_eq("rst_s", 32'(out_s), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame: lanes 1,0,1,0
      send_frame(4'b0101, 1'b0, 0);
      check_eq("t1_c", 32'(out_c), 32'h5);
      check_eq("t1_v", 32'(out_valid), 32'h1);
      idle_cyc();
      check_eq("t1_v_off", 32'(out_valid), 32'h0);

      // Same frame with 3-cycle gaps
      send_frame(4'b0101, 1'b0, 3);
      check_eq("t2_c", 32'(out_c), 32'h5);
      idle_cyc();

      // Partial frame dropped by a new start
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      send_frame(4'b1100, 1'b0, 0);
      check_eq("t3_c", 32'(out_c), 32'hC);
      check_eq("t3_v", 32'(out_valid), 32'h1);

      // Back-to-back frames
      send_frame(4'b0101, 1'b0, 0);
      check_eq("t4a_c", 32'(out_c), 32'h5);
      send_frame(4'b1111, 1'b0, 0);
      check_eq("t4b_c", 32'(out_c), 32'hF);
      check_eq("t4b_v", 32'(out_valid), 32'h1);

      // Reset mid-frame, then a full frame
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      async_reset();
      check_eq("t5_busy", 32'(out_busy), 32'h0);
      send_frame(4'b0011, 1'b0, 0);
      check_eq("t5_c", 32'(out_c), 32'h3);

      // Parity behaviour
      send_frame(4'b0101, 1'b0, 0);
      check_eq("t6a_perr", 32'(out_perr), 32'h0);
      send_frame(4'b0111, 1'b0, 0);
`ifdef DEMUX_PARITY_EN
      check_eq("t6b_perr", 32'(out_perr), 32'h1);
`else
      check_eq("t6b_perr", 32'(out_perr), 32'h0);
`endif
      check_eq("t6b_c", 32'(out_c), 32'h7);

      // Randomized traffic with one mid-run reset
      for (int i = 0; i < 600; i++) begin
         logic v, st;
         v  = ($urandom_range(0, 9) < 7);
         st = ($urandom_range(0, 9) < 2);
         cyc(v, st, 1'($urandom_range(0, 1)));
         if (i == 300) async_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
